// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, fetch FSM states and
// instruction field positions.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats load beats hold; reset and flush
// both leave a NOP behind.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'h0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack sequencing, one-entry skid for
// stalls and redirect handling, feeding the IF/ID register.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         if_id_valid,
  output logic [31:0]  if_id_instr,
  output logic [31:0]  if_id_pc_plus4,
  output logic [5:0]   opcode,
  output logic [5:0]   func,
  output fetch_state_e dbg_state
);

  // imem handshake: imem_req and imem_addr are held stable until the cycle
  // in which imem_ack is sampled high; that cycle completes the transfer and
  // imem_rdata is taken then. imem_ack outside a request is ignored.

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  pend_pc, pend_pc_nxt;
  logic [31:0]  skid_instr, skid_pc_plus4;
  logic         skid_load;
  logic         ifid_flush, ifid_load;
  logic [31:0]  ifid_instr_in, ifid_pc_plus4_in;
  logic [31:0]  pc_plus4, redir_pc;
  logic         unused_redirect_lsbs;

  assign pc_plus4             = pc + 32'd4;
  assign redir_pc             = word_align(redirect_pc);
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req  = (state == ST_FETCH) || (state == ST_DISCARD);
  assign imem_addr = pc;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RESET;
      pc            <= {RESET_PC[31:2], 2'b00};
      pend_pc       <= 32'h0;
      skid_instr    <= NOP_INSTR;
      skid_pc_plus4 <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      if (skid_load) begin
        skid_instr    <= imem_rdata;
        skid_pc_plus4 <= pc_plus4;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    pend_pc_nxt      = pend_pc;
    skid_load        = 1'b0;
    ifid_flush       = 1'b0;
    ifid_load        = 1'b0;
    ifid_instr_in    = imem_rdata;
    ifid_pc_plus4_in = pc_plus4;
    unique case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          if (imem_ack) begin
            pc_nxt = redir_pc;
          end else begin
            // Request is still outstanding: keep the address stable and
            // remember where to go once the stale word comes back.
            pend_pc_nxt = redir_pc;
            state_nxt   = ST_DISCARD;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_plus4;
          if (stall) begin
            skid_load = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_nxt     = redir_pc;
          state_nxt  = ST_FETCH;
        end else if (!stall) begin
          ifid_load        = 1'b1;
          ifid_instr_in    = skid_instr;
          ifid_pc_plus4_in = skid_pc_plus4;
          state_nxt        = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        ifid_flush = 1'b1;
        if (redirect) pend_pc_nxt = redir_pc;
        if (imem_ack) begin
          pc_nxt    = redirect ? redir_pc : pend_pc;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .flush         (ifid_flush),
    .load          (ifid_load),
    .load_instr    (ifid_instr_in),
    .load_pc_plus4 (ifid_pc_plus4_in),
    .valid         (if_id_valid),
    .instr         (if_id_instr),
    .pc_plus4      (if_id_pc_plus4)
  );

  assign opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];
  assign func   = if_id_instr[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: zero-wait streaming, stall/skid,
// slow memory with redirects, HOLD redirect, alignment and PC wrap.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         if_id_valid;
  logic [31:0]  if_id_instr;
  logic [31:0]  if_id_pc_plus4;
  logic [5:0]   opcode;
  logic [5:0]   func;
  fetch_state_e dbg_state;

  // zero-wait memory returns address-as-data in the request cycle
  logic         zw_mode;
  logic         man_ack;
  logic [31:0]  man_rdata;
  assign imem_ack   = zw_mode ? imem_req  : man_ack;
  assign imem_rdata = zw_mode ? imem_addr : man_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .opcode         (opcode),
    .func           (func),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check(tag, if_id_instr, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    zw_mode = 1'b1; man_ack = 1'b0; man_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset values and zero-wait streaming ----
    do_reset();
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4",   if_id_pc_plus4, 32'h0);
    check("rst_opfn",  {20'h0, opcode, func}, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_RESET));
    rst = 1'b0;
    step();
    check("zw_req1",  32'(imem_req), 32'h1);
    check("zw_addr0", imem_addr, 32'h0);
    check("zw_val0",  32'(if_id_valid), 32'h0);
    step();
    check("zw_addr4", imem_addr, 32'h4);
    check("zw_i0",    if_id_instr, 32'h0);
    check("zw_p4",    if_id_pc_plus4, 32'h4);
    check("zw_v0",    32'(if_id_valid), 32'h1);
    step();
    check("zw_addr8", imem_addr, 32'h8);
    check("zw_i4",    if_id_instr, 32'h4);
    check("zw_p8",    if_id_pc_plus4, 32'h8);
    step();
    check("zw_addrC", imem_addr, 32'hC);
    check("zw_i8",    if_id_instr, 32'h8);
    check("zw_pC",    if_id_pc_plus4, 32'hC);
    check("zw_v1",    32'(if_id_valid), 32'h1);

    // ---- stall while ack for addr 8 arrives ----
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    rst = 1'b0;
    step();
    step();
    check_sb("st_w0");
    step();
    check_sb("st_w4");
    check("st_addr8", imem_addr, 32'h8);
    stall = 1'b1;
    step();
    check("st_hold",   32'(dbg_state), 32'(ST_HOLD));
    check("st_noreq1", 32'(imem_req), 32'h0);
    check("st_keep1",  if_id_instr, 32'h4);
    step();
    check("st_noreq2", 32'(imem_req), 32'h0);
    check("st_keep2",  if_id_instr, 32'h4);
    step();
    check("st_noreq3", 32'(imem_req), 32'h0);
    check("st_keep3",  if_id_instr, 32'h4);
    stall = 1'b0;
    step();
    check_sb("st_w8");
    check("st_p8",     if_id_pc_plus4, 32'hC);
    check("st_addrC",  imem_addr, 32'hC);
    check("st_req",    32'(imem_req), 32'h1);
    step();
    check_sb("st_wC");
    check("st_pC",     if_id_pc_plus4, 32'h10);
    check("st_addr10", imem_addr, 32'h10);

    // ---- slow memory, redirect during outstanding fetch ----
    do_reset();
    rst = 1'b0;
    repeat (5) step();
    check("sl_addr10", imem_addr, 32'h10);
    check("sl_iC",     if_id_instr, 32'hC);
    zw_mode = 1'b0;
    step();
    check("sl_bubble", 32'(if_id_valid), 32'h0);
    check("sl_bub_i",  if_id_instr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("sl_disc",   32'(dbg_state), 32'(ST_DISCARD));
    check("sl_stable", imem_addr, 32'h10);
    check("sl_dreq",   32'(imem_req), 32'h1);
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    step();
    man_ack = 1'b0;
    check("sl_addr100", imem_addr, 32'h100);
    check("sl_drop",    32'(if_id_valid), 32'h0);
    step();
    check("sl_wait",    imem_addr, 32'h100);
    step();
    man_ack = 1'b1; man_rdata = 32'h8C48_0004;
    step();
    man_ack = 1'b0;
    check("sl_v",      32'(if_id_valid), 32'h1);
    check("sl_instr",  if_id_instr, 32'h8C48_0004);
    check("sl_pc4",    if_id_pc_plus4, 32'h104);
    check("sl_opcode", 32'(opcode), 32'h23);
    check("sl_func",   32'(func), 32'h04);
    check("sl_addr104", imem_addr, 32'h104);

    // ---- two redirects while discarding ----
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h300;
    check("dr_disc",  32'(dbg_state), 32'(ST_DISCARD));
    step();
    redirect = 1'b0;
    check("dr_stable", imem_addr, 32'h104);
    man_ack = 1'b1; man_rdata = 32'h0000_0BAD;
    step();
    man_ack = 1'b0;
    check("dr_addr300", imem_addr, 32'h300);
    check("dr_flush",   32'(if_id_valid), 32'h0);

    // ---- redirect with same-cycle ack, misaligned target ----
    redirect = 1'b1; redirect_pc = 32'h103; man_ack = 1'b1; man_rdata = 32'h0000_0BAD;
    step();
    redirect = 1'b0;
    check("al_addr100", imem_addr, 32'h100);
    check("al_state",   32'(dbg_state), 32'(ST_FETCH));
    check("al_drop",    32'(if_id_valid), 32'h0);
    man_rdata = 32'h0000_0020;
    step();
    check("hr_instrA",  if_id_instr, 32'h0000_0020);
    check("hr_pc4A",    if_id_pc_plus4, 32'h104);

    // ---- redirect while stalled in HOLD ----
    man_rdata = 32'h1234_5678; stall = 1'b1;
    step();
    man_ack = 1'b0;
    check("hr_hold",    32'(dbg_state), 32'(ST_HOLD));
    check("hr_noreq",   32'(imem_req), 32'h0);
    check("hr_keepA",   if_id_instr, 32'h0000_0020);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0; stall = 1'b0;
    check("hr_flush_v", 32'(if_id_valid), 32'h0);
    check("hr_flush_i", if_id_instr, 32'h0);
    check("hr_addr40",  imem_addr, 32'h40);
    check("hr_req",     32'(imem_req), 32'h1);
    man_ack = 1'b1; man_rdata = 32'h0C00_0010;
    step();
    check("hr_instrC",  if_id_instr, 32'h0C00_0010);
    check("hr_pc4C",    if_id_pc_plus4, 32'h44);
    check("hr_op",      32'(opcode), 32'h03);

    // ---- PC wrap at the top of the address space ----
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; man_rdata = 32'h0000_0BAD;
    step();
    redirect = 1'b0;
    check("wr_addr",  imem_addr, 32'hFFFF_FFFC);
    man_rdata = 32'hAC00_0000;
    step();
    man_ack = 1'b0;
    check("wr_instr", if_id_instr, 32'hAC00_0000);
    check("wr_pc4",   if_id_pc_plus4, 32'h0);
    check("wr_addr0", imem_addr, 32'h0);
    check("wr_op",    32'(opcode), 32'h2B);

    // ---- asynchronous reset while a fetch is outstanding ----
    #2;
    rst = 1'b1;
    #1;
    check("ar_req",   32'(imem_req), 32'h0);
    check("ar_addr",  imem_addr, 32'h0);
    check("ar_valid", 32'(if_id_valid), 32'h0);
    check("ar_instr", if_id_instr, 32'h0);
    check("ar_state", 32'(dbg_state), 32'(ST_RESET));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the MIPS pipeline. It is the producer side of the decode interface: it issues word fetches to instruction memory over a req/ack handshake, buffers returned words, and presents `opcode`/`func` plus the fetched instruction to the decode controller. It handles hazard stalls with a one-entry buffer and flushes on branch/jump redirects, including redirects that arrive while a fetch is outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (word aligned)
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `imem_req`  out  1  fetch request; held until `imem_ack`
- `imem_addr`  out  32  fetch address; stable while `imem_req` high; bits [1:0] always 0
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` valid this cycle; ignored unless `imem_req`
- `imem_rdata`  in  32  fetched instruction word
- `stall`  in  1  hazard unit: hold IF/ID contents
- `redirect`  in  1  one-cycle pulse from branch/jump/jr resolution
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0)
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_instr`  out  32  IF/ID instruction (32'h0 = NOP when invalid)
- `if_id_pc_plus4`  out  32  address of IF/ID instruction + 4 (for branch target / jal link)
- `opcode`  out  6  `if_id_instr[31:26]`
- `func`  out  6  `if_id_instr[5:0]`

## Operation
- States: RESET, FETCH, HOLD, DISCARD. `imem_req` = 1 in FETCH and DISCARD, 0 otherwise.
- Registers: `pc`, `pend_pc` (pending redirect target), skid {instr, pc_plus4}, IF/ID {valid, instr, pc_plus4}. `imem_addr` = `pc`.
- RESET: entered asynchronously; next edge -> FETCH.
- FETCH, priority order:
  - `redirect`: IF/ID flushed (valid 0, instr 0). If `imem_ack` same cycle: data dropped, `pc`<=`redirect_pc`, stay FETCH. Else `pend_pc`<=`redirect_pc`, -> DISCARD (`pc` unchanged so address stays stable).
  - `imem_ack` & !`stall`: IF/ID <= {1, `imem_rdata`, `pc`+4}; `pc`<=`pc`+4; stay FETCH.
  - `imem_ack` & `stall`: skid <= {`imem_rdata`, `pc`+4}; `pc`<=`pc`+4; IF/ID held; -> HOLD.
  - no ack & !`stall`: IF/ID valid<=0, instr<=0 (bubble).
  - no ack & `stall`: IF/ID held.
- HOLD: `redirect` -> skid dropped, IF/ID flushed, `pc`<=`redirect_pc`, -> FETCH. Else !`stall` -> IF/ID <= {1, skid}, -> FETCH. Else stay.
- DISCARD: IF/ID stays flushed. Further `redirect` updates `pend_pc` (latest wins). On `imem_ack`: data dropped, `pc`<=`pend_pc` (or `redirect_pc` if redirect same cycle), -> FETCH.
- `redirect` always overrides `stall`. PC arithmetic modulo 2^32 (wraps FFFF_FFFC -> 0000_0000).

## Timing
- Reset values: `imem_req` 0, `imem_addr` `RESET_PC`, `if_id_valid` 0, `if_id_instr` 0, `if_id_pc_plus4` 0, `opcode`/`func` 0; state RESET.
- First `imem_req` in the first cycle after the first edge following `rst` release.
- Zero-wait memory (ack in request cycle): one instruction per cycle; IF/ID updates on the ack edge, visible the following cycle.
- Redirect penalty with zero-wait memory: redirect edge fetches new PC next cycle; its instruction in IF/ID one cycle later.
- `rst` mid-fetch: outstanding request abandoned; memory must drop it; no state retained.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR` = 32'h0, fetch state enum, opcode field slice positions.
- One sub-module `if_id_reg`: IF/ID register with load/flush/hold controls and reset to NOP; FSM and PC logic stay in the top.

## Test plan
- Reset, zero-wait memory returning addr-as-data -> `imem_addr` 0,4,8,C on consecutive cycles; IF/ID instr 0,4,8 with pc_plus4 4,8,C, valid continuous.
- `stall` high 3 cycles while ack arrives for addr 8 -> IF/ID holds 4, no request during HOLD, after release IF/ID=8 then fetch resumes at C; no word lost or duplicated.
- 3-cycle-latency memory, `redirect`=0x100 one cycle after req for 0x10 -> `imem_addr` stays 0x10 until ack, data dropped, next req 0x100, IF/ID valid only for 0x100 word.
- Two redirects (0x200 then 0x300) during DISCARD -> next fetch 0x300.
- `redirect`=0x40 with `stall` high in HOLD -> skid dropped, IF/ID valid 0 next cycle, next fetch 0x40.
- `redirect_pc`=0x103 -> fetch 0x100; `pc`=FFFF_FFFC ack -> next fetch 0x0000_0000, pc_plus4 0.
